// File: rtl/fft_data_output.sv
// AXI4-Stream capture of one NFFT-sample complex frame into local RAM,
// read back through a registered 32-bit port once the frame is no longer being written.
module fft_data_output #(
   parameter int unsigned NFFT = 8
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   input  logic                        s_tlast,
   input  logic [63:0]                 s_tdata,
   input  logic [$clog2(NFFT*2)-1:0]   rAddr,
   input  logic                        rEn,
   output logic [31:0]                 rData,
   input  logic                        arm,
   output logic                        capturing,
   output logic                        done,
   output logic [$clog2(NFFT):0]       beat_count,
   output logic                        err_early_last,
   output logic                        err_no_last
);

   localparam int unsigned IW    = $clog2(NFFT);
   localparam int unsigned AW    = IW + 1;
   localparam int unsigned CW    = IW + 1;
   localparam int unsigned DEPTH = NFFT * 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DONE
   } state_e;

   state_e          state_q, state_d;
   logic            capturing_q, capturing_d;
   logic            done_q, done_d;
   logic            err_early_q, err_early_d;
   logic            err_no_last_q, err_no_last_d;
   logic [CW-1:0]   beat_count_q, beat_count_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [31:0]     ram [DEPTH];
   logic            ram_we_c;
   logic [AW-1:0]   ram_addr_re_c;
   logic [AW-1:0]   ram_addr_im_c;

   // Sample i lands as RE at word 2i and IM at word 2i+1.
   assign ram_addr_re_c = {beat_count_q[IW-1:0], 1'b0};
   assign ram_addr_im_c = {beat_count_q[IW-1:0], 1'b1};

   always_comb begin
      state_d       = state_q;
      done_d        = done_q;
      err_early_d   = err_early_q;
      err_no_last_d = err_no_last_q;
      beat_count_d  = beat_count_q;
      rdata_d       = rdata_q;
      ram_we_c      = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               state_d       = ST_CAPTURE;
               done_d        = 1'b0;
               err_early_d   = 1'b0;
               err_no_last_d = 1'b0;
               beat_count_d  = '0;
            end
         end
         ST_CAPTURE: begin
            if (s_tvalid) begin
               ram_we_c     = 1'b1;
               beat_count_d = beat_count_q + CW'(1);
               // The NFFT-th beat always closes the frame, with or without tlast.
               if (beat_count_q == CW'(NFFT - 1)) begin
                  state_d       = ST_DONE;
                  done_d        = 1'b1;
                  err_no_last_d = ~s_tlast;
               end else if (s_tlast) begin
                  state_d     = ST_DONE;
                  done_d      = 1'b1;
                  err_early_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The read port is locked while the frame is being written.
      if (rEn) begin
         rdata_d = (state_q == ST_CAPTURE) ? 32'd0 : ram[rAddr];
      end

      capturing_d = (state_d == ST_CAPTURE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         capturing_q   <= 1'b0;
         done_q        <= 1'b0;
         err_early_q   <= 1'b0;
         err_no_last_q <= 1'b0;
         beat_count_q  <= '0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         capturing_q   <= capturing_d;
         done_q        <= done_d;
         err_early_q   <= err_early_d;
         err_no_last_q <= err_no_last_d;
         beat_count_q  <= beat_count_d;
         rdata_q       <= rdata_d;
      end
   end

   // Frame storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (resetn && ram_we_c) begin
         ram[ram_addr_re_c] <= s_tdata[31:0];
         ram[ram_addr_im_c] <= s_tdata[63:32];
      end
   end

   assign s_tready       = capturing_q;
   assign capturing      = capturing_q;
   assign done           = done_q;
   assign err_early_last = err_early_q;
   assign err_no_last    = err_no_last_q;
   assign beat_count     = beat_count_q;
   assign rData          = rdata_q;

endmodule

// File: tb/tb_fft_data_output.sv
// Bench for fft_data_output: frames driven with random data and stalls, checked
// against a frame-level model of the expected RAM image and status flags.
module tb_fft_data_output;

   localparam int unsigned NFFT = 8;
   localparam int unsigned AW   = $clog2(NFFT*2);
   localparam int unsigned CW   = $clog2(NFFT) + 1;

   logic          clk;
   logic          resetn;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   logic [63:0]   s_tdata;
   logic [AW-1:0] rAddr;
   logic          rEn;
   logic [31:0]   rData;
   logic          arm;
   logic          capturing;
   logic          done;
   logic [CW-1:0] beat_count;
   logic          err_early_last;
   logic          err_no_last;

   int            vectors;
   int            miscompares;

   logic [63:0]   tx_data [16];
   logic [31:0]   exp_ram [2*NFFT];
   bit            exp_done, exp_early, exp_nolast;
   int            exp_count;

   fft_data_output #(.NFFT(NFFT)) dut (
      .clk(clk), .resetn(resetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
      .rAddr(rAddr), .rEn(rEn), .rData(rData),
      .arm(arm), .capturing(capturing), .done(done), .beat_count(beat_count),
      .err_early_last(err_early_last), .err_no_last(err_no_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic read_word(input int addr, output logic [31:0] data);
      rEn   = 1'b1;
      rAddr = AW'(addr);
      step();
      rEn   = 1'b0;
      data  = rData;
   endtask

   // Frame-level model: which beats land, where, and which flags result.
   task automatic model_frame(input int n, input int last_at);
      int acc = 0;
      exp_done = 0; exp_early = 0; exp_nolast = 0;
      for (int k = 0; k < n; k++) begin
         if (exp_done) break;
         exp_ram[2*acc]   = tx_data[k][31:0];
         exp_ram[2*acc+1] = tx_data[k][63:32];
         acc++;
         if (k == last_at) begin
            exp_done  = 1;
            exp_early = (acc < int'(NFFT));
         end else if (acc == int'(NFFT)) begin
            exp_done   = 1;
            exp_nolast = 1;
         end
      end
      exp_count = acc;
   endtask

   // Drives n beats from tx_data; counts beats that saw s_tready and watches stall cycles.
   task automatic send_frame(input int n, input int last_at, input int st_a, input int st_b,
                             input int st_len, input bit rnd,
                             output int acc, output bit ready_drop, output bit early_done);
      int sl;
      acc = 0; ready_drop = 0; early_done = 0;
      for (int k = 0; k < n; k++) begin
         s_tvalid = 1'b1;
         s_tdata  = tx_data[k];
         s_tlast  = (k == last_at);
         if (s_tready) acc++;
         step();
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         sl = 0;
         if (k == st_a || k == st_b) sl = st_len;
         else if (rnd && $urandom_range(3) == 0) sl = int'($urandom_range(3, 1));
         for (int j = 0; j < sl; j++) begin
            if (!s_tready) ready_drop = 1;
            if (done) early_done = 1;
            step();
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
      rAddr = '0; rEn = 1'b0; arm = 1'b0;
      step(); step();
      resetn = 1'b1;
      vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready got %b exp 0", s_tready); end
      vectors++; if (capturing !== 1'b0) begin miscompares++; $display("FAIL reset_capturing got %b exp 0", capturing); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
      vectors++; if ({err_early_last, err_no_last} !== 2'b00) begin miscompares++; $display("FAIL reset_errs got %b%b exp 00", err_early_last, err_no_last); end
      vectors++; if (beat_count !== CW'(0)) begin miscompares++; $display("FAIL reset_count got %0d exp 0", beat_count); end
      vectors++; if (rData !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", rData); end
   endtask

   task automatic test_nominal();
      int acc; bit rd, ed; logic [31:0] d;
      for (int k = 0; k < int'(NFFT); k++) tx_data[k] = {32'(k + 100), 32'(k)};
      model_frame(NFFT, NFFT - 1);
      do_arm();
      vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL nominal_tready_after_arm got %b exp 1", s_tready); end
      send_frame(NFFT, NFFT - 1, -1, -1, 0, 0, acc, rd, ed);
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL nominal_done got %b exp 1", done); end
      vectors++; if (beat_count !== CW'(exp_count)) begin miscompares++; $display("FAIL nominal_count got %0d exp %0d", beat_count, exp_count); end
      vectors++; if ({err_early_last, err_no_last} !== 2'b00) begin miscompares++; $display("FAIL nominal_errs got %b%b exp 00", err_early_last, err_no_last); end
      vectors++; if (acc != int'(NFFT)) begin miscompares++; $display("FAIL nominal_accepted got %0d exp %0d", acc, NFFT); end
      for (int k = 0; k < int'(NFFT); k++) begin
         read_word(2*k, d);
         vectors++; if (d !== 32'(k)) begin miscompares++; $display("FAIL nominal_re[%0d] got %0d exp %0d", k, d, k); end
         read_word(2*k + 1, d);
         vectors++; if (d !== 32'(k + 100)) begin miscompares++; $display("FAIL nominal_im[%0d] got %0d exp %0d", k, d, k + 100); end
      end
   endtask

   task automatic test_stall();
      int acc; bit rd, ed; logic [31:0] d;
      for (int k = 0; k < int'(NFFT); k++) tx_data[k] = {$urandom, $urandom};
      model_frame(NFFT, NFFT - 1);
      do_arm();
      send_frame(NFFT, NFFT - 1, 2, 5, 3, 0, acc, rd, ed);
      vectors++; if (rd !== 1'b0) begin miscompares++; $display("FAIL stall_tready_dropped got %b exp 0", rd); end
      vectors++; if (ed !== 1'b0) begin miscompares++; $display("FAIL stall_done_early got %b exp 0", ed); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got %b exp 1", done); end
      vectors++; if (beat_count !== CW'(exp_count)) begin miscompares++; $display("FAIL stall_count got %0d exp %0d", beat_count, exp_count); end
      for (int a = 0; a < int'(2*NFFT); a++) begin
         read_word(a, d);
         vectors++; if (d !== exp_ram[a]) begin miscompares++; $display("FAIL stall_ram[%0d] got %h exp %h", a, d, exp_ram[a]); end
      end
   endtask

   task automatic test_early_last();
      int acc; bit rd, ed; logic [31:0] d;
      for (int k = 0; k < int'(NFFT); k++) tx_data[k] = {$urandom, $urandom};
      model_frame(5, 4);
      do_arm();
      send_frame(5, 4, -1, -1, 0, 0, acc, rd, ed);
      vectors++; if (err_early_last !== 1'b1) begin miscompares++; $display("FAIL early_err got %b exp 1", err_early_last); end
      vectors++; if (err_no_last !== 1'b0) begin miscompares++; $display("FAIL early_nolast got %b exp 0", err_no_last); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL early_done got %b exp 1", done); end
      vectors++; if (beat_count !== CW'(5)) begin miscompares++; $display("FAIL early_count got %0d exp 5", beat_count); end
      vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL early_tready got %b exp 0", s_tready); end
      for (int a = 0; a < int'(2*NFFT); a++) begin
         read_word(a, d);
         vectors++; if (d !== exp_ram[a]) begin miscompares++; $display("FAIL early_ram[%0d] got %h exp %h", a, d, exp_ram[a]); end
      end
   endtask

   task automatic test_missing_last();
      int acc; bit rd, ed; logic [31:0] d;
      for (int k = 0; k < 9; k++) tx_data[k] = {$urandom, $urandom};
      model_frame(9, -1);
      do_arm();
      send_frame(9, -1, -1, -1, 0, 0, acc, rd, ed);
      vectors++; if (acc != exp_count) begin miscompares++; $display("FAIL nolast_accepted got %0d exp %0d", acc, exp_count); end
      vectors++; if (err_no_last !== 1'b1) begin miscompares++; $display("FAIL nolast_err got %b exp 1", err_no_last); end
      vectors++; if (err_early_last !== 1'b0) begin miscompares++; $display("FAIL nolast_early got %b exp 0", err_early_last); end
      vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL nolast_tready got %b exp 0", s_tready); end
      vectors++; if (beat_count !== CW'(NFFT)) begin miscompares++; $display("FAIL nolast_count got %0d exp %0d", beat_count, NFFT); end
      for (int a = 0; a < int'(2*NFFT); a++) begin
         read_word(a, d);
         vectors++; if (d !== exp_ram[a]) begin miscompares++; $display("FAIL nolast_ram[%0d] got %h exp %h", a, d, exp_ram[a]); end
      end
   endtask

   task automatic test_read_lock_rearm();
      int acc; bit rd, ed; logic [31:0] d;
      // Read issued on the arm edge still sees RAM.
      arm = 1'b1; rEn = 1'b1; rAddr = AW'(3);
      step();
      arm = 1'b0; rEn = 1'b0;
      vectors++; if (rData !== exp_ram[3]) begin miscompares++; $display("FAIL rearm_read_on_arm got %h exp %h", rData, exp_ram[3]); end
      vectors++; if ({done, err_early_last, err_no_last} !== 3'b000) begin miscompares++; $display("FAIL rearm_flags got %b%b%b exp 000", done, err_early_last, err_no_last); end
      vectors++; if (beat_count !== CW'(0)) begin miscompares++; $display("FAIL rearm_count got %0d exp 0", beat_count); end
      vectors++; if (capturing !== 1'b1) begin miscompares++; $display("FAIL rearm_capturing got %b exp 1", capturing); end
      read_word(5, d);
      vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL lock_read got %h exp 0", d); end
      rEn = 1'b0;
      step();
      vectors++; if (rData !== 32'd0) begin miscompares++; $display("FAIL lock_hold got %h exp 0", rData); end
      for (int k = 0; k < int'(NFFT); k++) tx_data[k] = {$urandom, $urandom};
      model_frame(NFFT, NFFT - 1);
      send_frame(NFFT, NFFT - 1, -1, -1, 0, 0, acc, rd, ed);
      vectors++; if ({done, err_early_last, err_no_last} !== 3'b100) begin miscompares++; $display("FAIL rearm_frame_flags got %b%b%b exp 100", done, err_early_last, err_no_last); end
      read_word(2*NFFT - 1, d);
      vectors++; if (d !== exp_ram[2*NFFT-1]) begin miscompares++; $display("FAIL rearm_last_word got %h exp %h", d, exp_ram[2*NFFT-1]); end
   endtask

   task automatic test_reset_mid();
      int acc; bit rd, ed; logic [31:0] d;
      for (int k = 0; k < int'(NFFT); k++) tx_data[k] = {$urandom, $urandom};
      model_frame(4, -1);
      do_arm();
      send_frame(4, -1, -1, -1, 0, 0, acc, rd, ed);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL midrst_tready got %b exp 0", s_tready); end
      vectors++; if (beat_count !== CW'(0)) begin miscompares++; $display("FAIL midrst_count got %0d exp 0", beat_count); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b exp 0", done); end
      for (int k = 0; k < int'(NFFT); k++) tx_data[k] = {$urandom, $urandom};
      model_frame(NFFT, NFFT - 1);
      do_arm();
      send_frame(NFFT, NFFT - 1, -1, -1, 0, 1, acc, rd, ed);
      vectors++; if ({done, err_early_last, err_no_last} !== 3'b100) begin miscompares++; $display("FAIL midrst_frame_flags got %b%b%b exp 100", done, err_early_last, err_no_last); end
      vectors++; if (beat_count !== CW'(NFFT)) begin miscompares++; $display("FAIL midrst_frame_count got %0d exp %0d", beat_count, NFFT); end
      for (int a = 0; a < int'(2*NFFT); a++) begin
         read_word(a, d);
         vectors++; if (d !== exp_ram[a]) begin miscompares++; $display("FAIL midrst_ram[%0d] got %h exp %h", a, d, exp_ram[a]); end
      end
   endtask

   task automatic test_random_frames();
      int acc, n, last_at, mode; bit rd, ed; logic [31:0] d;
      for (int it = 0; it < 12; it++) begin
         mode = int'($urandom_range(2));
         if (mode == 0) begin n = NFFT; last_at = NFFT - 1; end
         else if (mode == 1) begin n = int'($urandom_range(NFFT - 1, 1)); last_at = n - 1; end
         else begin n = int'($urandom_range(NFFT + 2, NFFT)); last_at = -1; end
         for (int k = 0; k < n; k++) tx_data[k] = {$urandom, $urandom};
         model_frame(n, last_at);
         do_arm();
         send_frame(n, last_at, -1, -1, 0, 1, acc, rd, ed);
         vectors++; if (acc != exp_count) begin miscompares++; $display("FAIL rand%0d_accepted got %0d exp %0d", it, acc, exp_count); end
         vectors++; if (beat_count !== CW'(exp_count)) begin miscompares++; $display("FAIL rand%0d_count got %0d exp %0d", it, beat_count, exp_count); end
         vectors++; if ({done, err_early_last, err_no_last} !== {exp_done, exp_early, exp_nolast}) begin
            miscompares++; $display("FAIL rand%0d_flags got %b%b%b exp %b%b%b", it, done, err_early_last, err_no_last, exp_done, exp_early, exp_nolast); end
         vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL rand%0d_tready got %b exp 0", it, s_tready); end
         for (int j = 0; j < 4; j++) begin
            int a = int'($urandom_range(2*NFFT - 1));
            read_word(a, d);
            vectors++; if (d !== exp_ram[a]) begin miscompares++; $display("FAIL rand%0d_ram[%0d] got %h exp %h", it, a, d, exp_ram[a]); end
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_nominal();
      test_stall();
      test_early_last();
      test_missing_last();
      test_read_lock_rearm();
      test_reset_mid();
      test_random_frames();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
